// File: rtl/matmul5_seq.sv
// rtl/matmul5_seq.sv - sequential 5x5 signed matrix multiplier, one MAC per clock
// MATMUL5_SATURATE_EN: clamp results to the signed WIDTH range instead of wrapping
module matmul5_seq #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a00, a01, a02, a03, a04,
    input  logic [WIDTH-1:0] a10, a11, a12, a13, a14,
    input  logic [WIDTH-1:0] a20, a21, a22, a23, a24,
    input  logic [WIDTH-1:0] a30, a31, a32, a33, a34,
    input  logic [WIDTH-1:0] a40, a41, a42, a43, a44,
    input  logic [WIDTH-1:0] b00, b01, b02, b03, b04,
    input  logic [WIDTH-1:0] b10, b11, b12, b13, b14,
    input  logic [WIDTH-1:0] b20, b21, b22, b23, b24,
    input  logic [WIDTH-1:0] b30, b31, b32, b33, b34,
    input  logic [WIDTH-1:0] b40, b41, b42, b43, b44,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p00, p01, p02, p03, p04,
    output logic [WIDTH-1:0] p10, p11, p12, p13, p14,
    output logic [WIDTH-1:0] p20, p21, p22, p23, p24,
    output logic [WIDTH-1:0] p30, p31, p32, p33, p34,
    output logic [WIDTH-1:0] p40, p41, p42, p43, p44
);

    localparam int ACCW = 2 * WIDTH + 3;
    localparam logic signed [ACCW-1:0] MAXV =
        $signed({{(ACCW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state;
    logic        [2:0]        i, j, k;
    logic signed [ACCW-1:0]   acc;
    logic signed [WIDTH-1:0]  a_r [25];
    logic signed [WIDTH-1:0]  b_r [25];
    logic        [WIDTH-1:0]  p_r [25];
    logic        [WIDTH-1:0]  a_in [25];
    logic        [WIDTH-1:0]  b_in [25];

    logic        [4:0]         a_idx, b_idx, p_idx;
    logic signed [WIDTH-1:0]   a_cur, b_cur;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    sum, scaled;
    logic        [WIDTH-1:0]   res;

    assign a_in = '{a00, a01, a02, a03, a04, a10, a11, a12, a13, a14,
                    a20, a21, a22, a23, a24, a30, a31, a32, a33, a34,
                    a40, a41, a42, a43, a44};
    assign b_in = '{b00, b01, b02, b03, b04, b10, b11, b12, b13, b14,
                    b20, b21, b22, b23, b24, b30, b31, b32, b33, b34,
                    b40, b41, b42, b43, b44};

    assign p00 = p_r[0];  assign p01 = p_r[1];  assign p02 = p_r[2];  assign p03 = p_r[3];  assign p04 = p_r[4];
    assign p10 = p_r[5];  assign p11 = p_r[6];  assign p12 = p_r[7];  assign p13 = p_r[8];  assign p14 = p_r[9];
    assign p20 = p_r[10]; assign p21 = p_r[11]; assign p22 = p_r[12]; assign p23 = p_r[13]; assign p24 = p_r[14];
    assign p30 = p_r[15]; assign p31 = p_r[16]; assign p32 = p_r[17]; assign p33 = p_r[18]; assign p34 = p_r[19];
    assign p40 = p_r[20]; assign p41 = p_r[21]; assign p42 = p_r[22]; assign p43 = p_r[23]; assign p44 = p_r[24];

    assign a_idx = 5'(i) * 5'd5 + 5'(k);
    assign b_idx = 5'(k) * 5'd5 + 5'(j);
    assign p_idx = 5'(i) * 5'd5 + 5'(j);
    assign a_cur = a_r[a_idx];
    assign b_cur = b_r[b_idx];

    // Operands are sign-extended explicitly so the full 2*WIDTH product is kept
    assign prod = $signed({{WIDTH{a_cur[WIDTH-1]}}, a_cur}) *
                  $signed({{WIDTH{b_cur[WIDTH-1]}}, b_cur});

    always_comb begin
        sum    = acc + $signed({{3{prod[2*WIDTH-1]}}, prod});
        scaled = sum >>> FRAC_BITS;
        res    = scaled[WIDTH-1:0];
`ifdef MATMUL5_SATURATE_EN
        if (scaled > MAXV) begin
            res = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (scaled < MINV) begin
            res = {1'b1, {(WIDTH - 1){1'b0}}};
        end
`endif
    end

`ifndef MATMUL5_SATURATE_EN
    logic unused_hi;
    assign unused_hi = ^scaled[ACCW-1:WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            i     <= 3'd0;
            j     <= 3'd0;
            k     <= 3'd0;
            acc   <= '0;
            for (int n = 0; n < 25; n++) begin
                a_r[n] <= '0;
                b_r[n] <= '0;
                p_r[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int n = 0; n < 25; n++) begin
                            a_r[n] <= a_in[n];
                            b_r[n] <= b_in[n];
                        end
                        acc   <= '0;
                        i     <= 3'd0;
                        j     <= 3'd0;
                        k     <= 3'd0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (k == 3'd4) begin
                        // Final term of a dot product: write the entry and restart the sum
                        p_r[p_idx] <= res;
                        acc        <= '0;
                        k          <= 3'd0;
                        if (j == 3'd4) begin
                            j <= 3'd0;
                            if (i == 3'd4) begin
                                i     <= 3'd0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                i <= i + 3'd1;
                            end
                        end else begin
                            j <= j + 3'd1;
                        end
                    end else begin
                        acc <= sum;
                        k   <= k + 3'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul5_seq.sv
// tb/tb_matmul5_seq.sv - self-checking bench for matmul5_seq
// Integer and FRAC_BITS=16 instances checked against a plain-arithmetic matrix model
module tb_matmul5_seq;

    logic        clk = 1'b0;
    logic        rst, start1, start2;
    logic [31:0] a [25];
    logic [31:0] b [25];
    logic [31:0] p1 [25];
    logic [31:0] p2 [25];
    logic [31:0] expv [25];
    logic        busy1, done1, busy2, done2;
    int          passed = 0, failed = 0, total = 0;
    int          lat, bcnt, dcnt;

    always #5 clk = ~clk;

    matmul5_seq #(.WIDTH(32), .FRAC_BITS(0)) u_int (
        .clk(clk), .rst(rst), .start(start1),
        .a00(a[0]),  .a01(a[1]),  .a02(a[2]),  .a03(a[3]),  .a04(a[4]),
        .a10(a[5]),  .a11(a[6]),  .a12(a[7]),  .a13(a[8]),  .a14(a[9]),
        .a20(a[10]), .a21(a[11]), .a22(a[12]), .a23(a[13]), .a24(a[14]),
        .a30(a[15]), .a31(a[16]), .a32(a[17]), .a33(a[18]), .a34(a[19]),
        .a40(a[20]), .a41(a[21]), .a42(a[22]), .a43(a[23]), .a44(a[24]),
        .b00(b[0]),  .b01(b[1]),  .b02(b[2]),  .b03(b[3]),  .b04(b[4]),
        .b10(b[5]),  .b11(b[6]),  .b12(b[7]),  .b13(b[8]),  .b14(b[9]),
        .b20(b[10]), .b21(b[11]), .b22(b[12]), .b23(b[13]), .b24(b[14]),
        .b30(b[15]), .b31(b[16]), .b32(b[17]), .b33(b[18]), .b34(b[19]),
        .b40(b[20]), .b41(b[21]), .b42(b[22]), .b43(b[23]), .b44(b[24]),
        .busy(busy1), .done(done1),
        .p00(p1[0]),  .p01(p1[1]),  .p02(p1[2]),  .p03(p1[3]),  .p04(p1[4]),
        .p10(p1[5]),  .p11(p1[6]),  .p12(p1[7]),  .p13(p1[8]),  .p14(p1[9]),
        .p20(p1[10]), .p21(p1[11]), .p22(p1[12]), .p23(p1[13]), .p24(p1[14]),
        .p30(p1[15]), .p31(p1[16]), .p32(p1[17]), .p33(p1[18]), .p34(p1[19]),
        .p40(p1[20]), .p41(p1[21]), .p42(p1[22]), .p43(p1[23]), .p44(p1[24])
    );

    matmul5_seq #(.WIDTH(32), .FRAC_BITS(16)) u_fix (
        .clk(clk), .rst(rst), .start(start2),
        .a00(a[0]),  .a01(a[1]),  .a02(a[2]),  .a03(a[3]),  .a04(a[4]),
        .a10(a[5]),  .a11(a[6]),  .a12(a[7]),  .a13(a[8]),  .a14(a[9]),
        .a20(a[10]), .a21(a[11]), .a22(a[12]), .a23(a[13]), .a24(a[14]),
        .a30(a[15]), .a31(a[16]), .a32(a[17]), .a33(a[18]), .a34(a[19]),
        .a40(a[20]), .a41(a[21]), .a42(a[22]), .a43(a[23]), .a44(a[24]),
        .b00(b[0]),  .b01(b[1]),  .b02(b[2]),  .b03(b[3]),  .b04(b[4]),
        .b10(b[5]),  .b11(b[6]),  .b12(b[7]),  .b13(b[8]),  .b14(b[9]),
        .b20(b[10]), .b21(b[11]), .b22(b[12]), .b23(b[13]), .b24(b[14]),
        .b30(b[15]), .b31(b[16]), .b32(b[17]), .b33(b[18]), .b34(b[19]),
        .b40(b[20]), .b41(b[21]), .b42(b[22]), .b43(b[23]), .b44(b[24]),
        .busy(busy2), .done(done2),
        .p00(p2[0]),  .p01(p2[1]),  .p02(p2[2]),  .p03(p2[3]),  .p04(p2[4]),
        .p10(p2[5]),  .p11(p2[6]),  .p12(p2[7]),  .p13(p2[8]),  .p14(p2[9]),
        .p20(p2[10]), .p21(p2[11]), .p22(p2[12]), .p23(p2[13]), .p24(p2[14]),
        .p30(p2[15]), .p31(p2[16]), .p32(p2[17]), .p33(p2[18]), .p34(p2[19]),
        .p40(p2[20]), .p41(p2[21]), .p42(p2[22]), .p43(p2[23]), .p44(p2[24])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: P = A x B in wide integer arithmetic, scaled, then wrapped or clamped
    function automatic void model(input int frac);
        logic signed [66:0] s;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                s = '0;
                for (int t = 0; t < 5; t++)
                    s = s + $signed(a[r*5+t]) * $signed(b[t*5+c]);
                s = s >>> frac;
                expv[r*5+c] = s[31:0];
`ifdef MATMUL5_SATURATE_EN
                if (s > 67'sd2147483647) expv[r*5+c] = 32'h7FFFFFFF;
                else if (s < -67'sd2147483648) expv[r*5+c] = 32'h80000000;
`endif
            end
        end
    endfunction

    task automatic chk_matrix(input string tag, input bit sel);
        for (int n = 0; n < 25; n++)
            chk($sformatf("%s p%0d%0d", tag, n / 5, n % 5), sel ? p2[n] : p1[n], expv[n]);
    endtask

    // mode 0: plain run; 1: disturb inputs at +5 and re-pulse start at +10; 2: reset at +60
    task automatic run(input bit sel, input int mode, output int latency, output int busy_cycles);
        latency = -1;
        busy_cycles = 0;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            if (sel ? busy2 : busy1) busy_cycles++;
            if (sel ? done2 : done1) begin
                latency = n;
                break;
            end
            if (mode == 1 && n == 5)
                for (int q = 0; q < 25; q++) begin a[q] = $urandom; b[q] = $urandom; end
            if (mode == 1 && n == 10) start1 = 1'b1;
            if (mode == 2 && n == 60) begin
                rst = 1'b1;
                latency = 0;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input bit sel);
        run(sel, 0, lat, bcnt);
        chk({tag, " latency"}, lat, 126);
        chk({tag, " busy cycles"}, bcnt, 125);
        chk_matrix(tag, sel);
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        for (int n = 0; n < 25; n++) begin a[n] = '0; b[n] = '0; end
        repeat (3) @(negedge clk);
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset p00", p1[0], 0);
        chk("reset p44", p1[24], 0);
        chk("reset fix busy", busy2, 0);
        rst = 1'b0;

        for (int n = 0; n < 25; n++) begin
            a[n] = 32'((n / 5) + 1 + ((n / 5 == n % 5 && n / 5 != 0) ? 1 : 0));
            b[n] = (n / 5 == n % 5) ? 32'd1 : 32'd0;
        end
        model(0);
        run_check("identity", 0);
        chk("identity p11 literal", p1[6], 32'd3);

        for (int n = 0; n < 25; n++) begin a[n] = 32'd2; b[n] = 32'd3; end
        model(0);
        run_check("const2x3", 0);
        chk("const2x3 literal", p1[12], 32'd30);

        for (int n = 0; n < 25; n++) begin a[n] = 32'hFFFFFFFF; b[n] = 32'd7; end
        model(0);
        run_check("constm1x7", 0);
        chk("constm1x7 literal", p1[24], 32'hFFFFFFDD);

        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 25; n++) begin a[n] = $urandom; b[n] = $urandom; end
            model(0);
            run_check($sformatf("rand%0d", r), 0);
        end
        for (int n = 0; n < 25; n++) begin
            a[n] = 32'($signed($urandom_range(0, 200)) - 100);
            b[n] = 32'($signed($urandom_range(0, 200)) - 100);
        end
        model(0);
        run_check("small", 0);

        for (int n = 0; n < 25; n++) begin
            a[n] = (n / 5 == n % 5) ? 32'h00010000 : 32'd0;
            b[n] = 32'h00018000;
        end
        model(16);
        run_check("fix1p5", 1);
        chk("fix1p5 literal", p2[7], 32'h00018000);
        for (int n = 0; n < 25; n++) b[n] = 32'hFFFF8000;
        model(16);
        run_check("fixm0p5", 1);
        chk("fixm0p5 literal", p2[18], 32'hFFFF8000);
        for (int n = 0; n < 25; n++) begin a[n] = $urandom; b[n] = $urandom; end
        model(16);
        run_check("fixrand", 1);

        for (int n = 0; n < 25; n++) begin a[n] = '0; b[n] = '0; end
        a[0] = 32'h40000000;
        b[0] = 32'h40000000;
        model(0);
        run_check("overflow", 0);
`ifdef MATMUL5_SATURATE_EN
        chk("overflow p00 literal", p1[0], 32'h7FFFFFFF);
`else
        chk("overflow p00 literal", p1[0], 32'h00000000);
`endif

        for (int n = 0; n < 25; n++) begin a[n] = $urandom; b[n] = $urandom; end
        model(0);
        run(0, 1, lat, bcnt);
        chk("handshake latency", lat, 126);
        chk("handshake busy cycles", bcnt, 125);
        chk_matrix("handshake", 0);
        repeat (3) @(negedge clk);
        chk("handshake no requeue", busy1, 0);

        for (int n = 0; n < 25; n++) begin a[n] = $urandom; b[n] = $urandom; end
        run(0, 2, lat, bcnt);
        chk("midreset reached", lat, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", busy1, 0);
        chk("midreset done", done1, 0);
        for (int n = 0; n < 25; n++)
            chk($sformatf("midreset p%0d%0d", n / 5, n % 5), p1[n], 0);
        dcnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        chk("midreset no done", dcnt, 0);
        model(0);
        run_check("after reset", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
